// File: rtl/core_bus_master.sv
// Per-core bus front end: in-order store buffer with load forwarding, one bus transaction in flight.
// Stores reach the bus accept+2 cycles; forwarded loads return in 1 cycle; cpu_ready drops on full buffer or pending load.
module core_bus_master #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              sb_empty
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_REQ  = 2'd1;
  localparam logic [1:0] RD_REQ  = 2'd2;
  localparam logic [1:0] RD_WAIT = 2'd3;

  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state, next_state;
  logic              load_pending;
  logic [ADDR_W-1:0] ld_addr;

  logic              sb_full, st_acc, ld_acc, pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign sb_full   = (count == CNT_W'(SB_DEPTH));
  assign cpu_ready = !load_pending && (cpu_we ? !sb_full : 1'b1);
  assign st_acc    = cpu_valid && cpu_ready && cpu_we;
  assign ld_acc    = cpu_valid && cpu_ready && !cpu_we;
  assign pop       = (state == WR_REQ) && bus_grant;
  assign sb_empty  = (count == '0) && (state != WR_REQ);

  // Scan oldest to youngest so the youngest matching store wins. The write
  // in flight is still the head entry until its grant, so it is covered here.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = head;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (sb_addr[idx] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[idx];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load_pending)       next_state = RD_REQ;
        else if (count != '0)   next_state = WR_REQ;
      end
      WR_REQ:  if (bus_grant)  next_state = IDLE;
      RD_REQ:  if (bus_grant)  next_state = RD_WAIT;
      RD_WAIT: if (bus_rvalid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_acc) begin
      sb_addr[tail] <= cpu_addr;
      sb_data[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      load_pending <= 1'b0;
      ld_addr      <= '0;
      bus_request  <= 1'b0;
      bus_rw       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      cpu_rvalid   <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      state <= next_state;
      if (st_acc) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      case ({st_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Bus fields are latched only on entry to a request state, so they stay
      // frozen while the arbiter withholds the grant.
      bus_request <= (next_state == WR_REQ) || (next_state == RD_REQ);
      if (state == IDLE && next_state == WR_REQ) begin
        bus_rw    <= 1'b1;
        bus_addr  <= sb_addr[head];
        bus_wdata <= sb_data[head];
      end
      if (state == IDLE && next_state == RD_REQ) begin
        bus_rw   <= 1'b0;
        bus_addr <= ld_addr;
      end

      cpu_rvalid <= 1'b0;
      if (ld_acc) begin
        if (fwd_hit) begin
          cpu_rdata  <= fwd_data;
          cpu_rvalid <= 1'b1;
        end else begin
          load_pending <= 1'b1;
          ld_addr      <= cpu_addr;
        end
      end
      if (state == RD_WAIT && bus_rvalid) begin
        cpu_rdata    <= bus_rdata;
        cpu_rvalid   <= 1'b1;
        load_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_bus_master.sv
// Scoreboard bench for core_bus_master: directed stimulus pushes expectations, a negedge monitor pops them.
module tb_core_bus_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_valid, cpu_we;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ready, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       bus_request, bus_grant, bus_rw;
  logic [8:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_rvalid;
  logic [7:0] bus_rdata;
  logic       sb_empty;

  // bus responder controls
  logic       grant_en, rd_en, man_grant, man_rvalid, pend_rd;
  logic [7:0] rd_val;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_wr[$];
  logic [8:0]  exp_rdaddr[$];
  logic [7:0]  exp_rd[$];
  logic [9:0]  bus_log[$];

  always #5 clk = ~clk;

  core_bus_master dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .bus_request(bus_request), .bus_grant(bus_grant), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .sb_empty(sb_empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arbiter/RAM model: grants a pending request, returns read data one cycle after a read grant.
  initial begin
    bus_grant = 1'b0; bus_rvalid = 1'b0; bus_rdata = 8'h00; pend_rd = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus_grant  = 1'b0;
      bus_rvalid = man_rvalid;
      if (man_rvalid) bus_rdata = 8'hEE;
      if (pend_rd) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rd_val;
        pend_rd    = 1'b0;
      end else if (bus_request && (grant_en || man_grant)) begin
        bus_grant = 1'b1;
        if (!bus_rw && rd_en) pend_rd = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus_request && bus_grant) begin
        bus_log.push_back({bus_rw, bus_addr});
        if (bus_rw) begin
          chk("bus_write_expected", int'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) chk("bus_write", {bus_addr, bus_wdata}, exp_wr.pop_front());
        end else begin
          chk("bus_read_expected", int'(exp_rdaddr.size() > 0), 1);
          if (exp_rdaddr.size() > 0) chk("bus_read_addr", bus_addr, exp_rdaddr.pop_front());
        end
      end
      if (cpu_rvalid) begin
        chk("cpu_rvalid_expected", int'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) chk("cpu_rdata", cpu_rdata, exp_rd.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic we, input logic [8:0] a, input logic [7:0] d);
    int n = 0;
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (!cpu_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", cpu_ready, 1);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic store(input logic [8:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    do_req(1'b1, a, d);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(sb_empty && exp_wr.size() == 0 && exp_rd.size() == 0) && n < 100) begin
      tick();
      n++;
    end
    chk(name, int'(sb_empty && exp_wr.size() == 0 && exp_rd.size() == 0), 1);
  endtask

  initial begin
    int base;
    logic [8:0] a;
    reset = 1'b1; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    grant_en = 1'b0; rd_en = 1'b0; man_grant = 1'b0; man_rvalid = 1'b0; rd_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_bus_request", bus_request, 0);
    chk("reset_cpu_rvalid", cpu_rvalid, 0);
    chk("reset_sb_empty", sb_empty, 1);
    chk("reset_cpu_ready", cpu_ready, 1);
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_bus_addr", bus_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset while waiting for read data, then a stray bus_rvalid
    grant_en = 1'b1; rd_en = 1'b0;
    exp_rdaddr.push_back(9'h100);
    do_req(1'b0, 9'h100, 8'h00);
    repeat (4) tick();
    chk("t1_load_pending_blocks", cpu_ready, 0);
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("t1_rst_bus_request", bus_request, 0);
      chk("t1_rst_cpu_rvalid", cpu_rvalid, 0);
      chk("t1_rst_sb_empty", sb_empty, 1);
    end
    reset = 1'b0; man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    repeat (3) begin
      tick();
      chk("t1_stray_rvalid", cpu_rvalid, 0);
    end
    chk("t1_ready_after_reset", cpu_ready, 1);

    // Two stores drain in order
    rd_en = 1'b1;
    store(9'h010, 8'hAA);
    store(9'h011, 8'hBB);
    wait_drain("t2_drain");

    // Fill the buffer with grants held off
    grant_en = 1'b0;
    for (int i = 0; i < 4; i++) store(9'h030 + 9'(i), 8'h30 + 8'(i));
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h034; cpu_wdata = 8'h34;
    @(negedge clk);
    chk("t3_full_ready", cpu_ready, 0);
    chk("t3_sb_empty", sb_empty, 0);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 9'h031;
    @(negedge clk);
    chk("t3_load_ready", cpu_ready, 1);
    exp_rd.push_back(8'h31);
    @(posedge clk); #1;
    cpu_valid = 1'b0; man_grant = 1'b1;
    tick();
    man_grant = 1'b0;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h034; cpu_wdata = 8'h34;
    @(negedge clk);
    chk("t3_ready_after_grant", cpu_ready, 1);
    exp_wr.push_back({9'h034, 8'h34});
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    grant_en = 1'b1;
    wait_drain("t3_drain");

    // Forwarding of the youngest store
    grant_en = 1'b0;
    store(9'h020, 8'h11);
    store(9'h020, 8'h22);
    exp_rd.push_back(8'h22);
    do_req(1'b0, 9'h020, 8'h00);
    @(negedge clk);
    chk("t4_fwd_rvalid", cpu_rvalid, 1);
    chk("t4_fwd_data", cpu_rdata, 8'h22);
    grant_en = 1'b1;
    wait_drain("t4_drain");

    // Load miss overtakes the second buffered store
    grant_en = 1'b0; rd_val = 8'h5C;
    store(9'h040, 8'h44);
    store(9'h041, 8'h45);
    repeat (2) tick();
    base = bus_log.size();
    exp_rdaddr.push_back(9'h1FF);
    exp_rd.push_back(8'h5C);
    do_req(1'b0, 9'h1FF, 8'h00);
    chk("t5_wr_hold_rw", bus_rw, 1);
    chk("t5_wr_hold_addr", bus_addr, 9'h040);
    grant_en = 1'b1;
    wait_drain("t5_drain");
    chk("t5_log_len", bus_log.size() - base, 3);
    if (bus_log.size() >= base + 3) begin
      chk("t5_order0", bus_log[base],     {1'b1, 9'h040});
      chk("t5_order1", bus_log[base + 1], {1'b0, 9'h1FF});
      chk("t5_order2", bus_log[base + 2], {1'b1, 9'h041});
    end
    chk("t5_rdata_held", cpu_rdata, 8'h5C);

    // Request fields stay frozen while the grant is withheld
    grant_en = 1'b0;
    store(9'h050, 8'h55);
    repeat (2) tick();
    chk("t6_request_up", bus_request, 1);
    for (int i = 0; i < 10; i++) begin
      cpu_valid = 1'b1;
      cpu_we    = (i % 2 == 0);
      a         = 9'h060 + 9'(i);
      cpu_addr  = cpu_we ? a : 9'h050;
      cpu_wdata = 8'h60 + 8'(i);
      @(negedge clk);
      chk("t6_bus_request", bus_request, 1);
      chk("t6_bus_rw", bus_rw, 1);
      chk("t6_bus_addr", bus_addr, 9'h050);
      chk("t6_bus_wdata", bus_wdata, 8'h55);
      if (cpu_ready) begin
        if (cpu_we) exp_wr.push_back({cpu_addr, cpu_wdata});
        else        exp_rd.push_back(8'h55);
      end
      @(posedge clk); #1;
    end
    cpu_valid = 1'b0;
    grant_en = 1'b1;
    wait_drain("t6_drain");

    repeat (5) tick();
    chk("end_exp_wr_empty", exp_wr.size(), 0);
    chk("end_exp_rd_empty", exp_rd.size(), 0);
    chk("end_exp_rdaddr_empty", exp_rdaddr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
